pacman_motion_ctrl: RTL and testbench

- Computes the Pac-Man sprite centre (PacmanX/PacmanY) consumed by color_mapper each frame.
- Turns USB keyboard keycodes into a buffered "next direction".
- On every frame tick, advances the sprite one step through the 40x30 tile maze, querying an external wall-bit ROM.
- Handles wall stops, cornering at tile centres, instant reversal and the horizontal tunnel wrap.

---
 rtl/pacman_pkg.sv | 26 ++
 rtl/neighbor_tile_calc.sv | 43 ++++
 rtl/pacman_motion_ctrl.sv | 155 +++++++++++++++
 tb/tb_pacman_motion_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man motion controller.
package pacman_pkg;

    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

    typedef enum logic [2:0] {IDLE, REQ_Q, CHK_Q, REQ_C, CHK_C, UPDATE} state_t;

    localparam int TILE      = 16;
    localparam int MAZE_COLS = 40;
    localparam int MAZE_ROWS = 30;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

endpackage

// File: rtl/neighbor_tile_calc.sv
// Neighbour tile of (row, col) in a direction: wall-ROM address plus
// off-map / tunnel-wrap flags. Purely combinational.
module neighbor_tile_calc
    import pacman_pkg::*;
#(
    parameter int TUNNEL_ROW = 14
) (
    input  logic [4:0]  row_i,
    input  logic [5:0]  col_i,
    input  dir_t        dir_i,
    output logic [10:0] wall_addr_o,
    output logic        off_map_o,
    output logic        wrap_o
);

    logic [4:0] row_n;
    logic [5:0] col_n;
    logic       horiz;

    // Step one tile; flag edges instead of wrapping the arithmetic
    always_comb begin
        row_n     = row_i;
        col_n     = col_i;
        off_map_o = 1'b0;
        horiz     = 1'b0;
        case (dir_i)
            UP:    if (row_i == 5'd0) off_map_o = 1'b1; else row_n = row_i - 5'd1;
            DOWN:  if (row_i == 5'(MAZE_ROWS - 1)) off_map_o = 1'b1; else row_n = row_i + 5'd1;
            LEFT: begin
                horiz = 1'b1;
                if (col_i == 6'd0) off_map_o = 1'b1; else col_n = col_i - 6'd1;
            end
            default: begin
                horiz = 1'b1;
                if (col_i == 6'(MAZE_COLS - 1)) off_map_o = 1'b1; else col_n = col_i + 6'd1;
            end
        endcase
        // Leaving the map sideways on the tunnel row is the only open exit
        wrap_o      = off_map_o && horiz && (row_i == 5'(TUNNEL_ROW));
        wall_addr_o = {row_n, col_n};
    end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man sprite motion: keycode -> queued direction, one step per frame
// tick through the tile maze with wall-ROM lookups, cornering, reversal
// and tunnel wrap.
module pacman_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int STEP       = 1,
    parameter int START_X    = 312,
    parameter int START_Y    = 376,
    parameter int TUNNEL_ROW = 14
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [7:0]  keycode,
    output logic [10:0] wall_addr,
    input  logic        wall_bit,
    output logic [9:0]  PacmanX,
    output logic [9:0]  PacmanY,
    output logic [1:0]  pac_dir,
    output logic        moving,
    output logic        busy
);

    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam logic [9:0] X_MIN  = 10'(TILE / 2);
    localparam logic [9:0] X_MAX  = 10'(MAZE_COLS * TILE - TILE / 2);

    state_t      state_q;
    dir_t        dir_q, qdir_q, qdir_d, try_q, nb_dir;
    logic [9:0]  x_q, y_q, x_d, y_d;
    logic [10:0] addr_q, nb_addr;
    logic        moving_q, pending_q, off_q, wrap_q, move_q;
    logic        nb_off, nb_wrap, nb_open, aligned;

    assign aligned = (x_q[3:0] == 4'd8) && (y_q[3:0] == 4'd8);
    // IDLE probes the queued direction, CHK_Q falls back to the current one
    assign nb_dir  = (state_q == CHK_Q) ? dir_q : qdir_q;
    // Off-map neighbours never touch the ROM; their openness is the wrap flag
    assign nb_open = off_q ? wrap_q : ~wall_bit;

    neighbor_tile_calc #(.TUNNEL_ROW(TUNNEL_ROW)) u_nb (
        .row_i      (y_q[8:4]),
        .col_i      (x_q[9:4]),
        .dir_i      (nb_dir),
        .wall_addr_o(nb_addr),
        .off_map_o  (nb_off),
        .wrap_o     (nb_wrap)
    );

    // Keycode decode into the next queued direction
    always_comb begin
        qdir_d = qdir_q;
        case (keycode)
            KEY_W:   qdir_d = UP;
            KEY_S:   qdir_d = DOWN;
            KEY_A:   qdir_d = LEFT;
            KEY_D:   qdir_d = RIGHT;
            default: ;
        endcase
    end

    // One STEP displacement in the committed heading, with tunnel wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (move_q) begin
            case (dir_q)
                UP:      y_d = y_q - STEP_W;
                DOWN:    y_d = y_q + STEP_W;
                LEFT:    x_d = (wrap_q && x_q == X_MIN) ? X_MAX : x_q - STEP_W;
                default: x_d = (wrap_q && x_q == X_MAX) ? X_MIN : x_q + STEP_W;
            endcase
        end
    end

    // Queued direction latch, updated every cycle
    always_ff @(posedge Clk) begin
        if (Reset) qdir_q <= LEFT;
        else       qdir_q <= qdir_d;
    end

    // Motion FSM with registered position, heading and ROM address
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            x_q       <= 10'(START_X);
            y_q       <= 10'(START_Y);
            dir_q     <= LEFT;
            try_q     <= LEFT;
            moving_q  <= 1'b0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            off_q     <= 1'b0;
            wrap_q    <= 1'b0;
            move_q    <= 1'b0;
        end else begin
            // One tick can be queued while a service is in flight
            if (state_q != IDLE && frame_tick) pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (frame_tick || pending_q) begin
                        pending_q <= 1'b0;
                        if (!aligned) begin
                            // Mid-tile: only an about-turn may change heading
                            if (qdir_q == opposite(dir_q)) dir_q <= qdir_q;
                            move_q  <= 1'b1;
                            wrap_q  <= 1'b0;
                            state_q <= UPDATE;
                        end else begin
                            try_q  <= qdir_q;
                            off_q  <= nb_off;
                            wrap_q <= nb_wrap;
                            if (!nb_off) addr_q <= nb_addr;
                            state_q <= REQ_Q;
                        end
                    end
                end
                REQ_Q: state_q <= CHK_Q;
                CHK_Q: begin
                    if (nb_open) begin
                        dir_q   <= try_q;
                        move_q  <= 1'b1;
                        state_q <= UPDATE;
                    end else begin
                        off_q  <= nb_off;
                        wrap_q <= nb_wrap;
                        if (!nb_off) addr_q <= nb_addr;
                        state_q <= REQ_C;
                    end
                end
                REQ_C: state_q <= CHK_C;
                CHK_C: begin
                    move_q  <= nb_open;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    x_q      <= x_d;
                    y_q      <= y_d;
                    moving_q <= move_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wall_addr = addr_q;
    assign PacmanX   = x_q;
    assign PacmanY   = y_q;
    assign pac_dir   = dir_q;
    assign moving    = moving_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: scripted vector table, corner sequences
// and random walks through a random maze against a tile-level model.
module tb_pacman_motion_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [10:0] wall_addr;
    logic        wall_bit = 1'b0;
    logic [9:0]  PacmanX, PacmanY;
    logic [1:0]  pac_dir;
    logic        moving, busy;

    int nchecks = 0;
    int nerrors = 0;

    bit maze [0:29][0:39];

    // reference model state (directions: 0 up, 1 down, 2 left, 3 right)
    int mx, my, mdir, mq, mmov;
    int DR [4]  = '{-1, 1, 0, 0};
    int DC [4]  = '{0, 0, -1, 1};
    int OPP [4] = '{1, 0, 3, 2};

    typedef struct {
        logic [7:0] key;
        int x, y, dir, mov, cyc;
    } vec_t;
    vec_t vt [12];

    pacman_motion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
        .wall_addr(wall_addr), .wall_bit(wall_bit), .PacmanX(PacmanX),
        .PacmanY(PacmanY), .pac_dir(pac_dir), .moving(moving), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // synchronous wall ROM: data valid one clock after the address
    always @(posedge Clk) begin
        if (wall_addr[10:6] < 5'd30 && wall_addr[5:0] < 6'd40)
            wall_bit <= maze[wall_addr[10:6]][wall_addr[5:0]];
        else
            wall_bit <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_open(input int x, input int y, input int d);
        int r, c;
        r = y / 16 + DR[d];
        c = x / 16 + DC[d];
        if (r < 0 || r >= 30) return 1'b0;
        if (c < 0 || c >= 40) return (r == 14);
        return !maze[r][c];
    endfunction

    task automatic model_reset();
        mx = 312; my = 376; mdir = 2; mq = 2; mmov = 0;
    endtask

    task automatic model_tick();
        bit al;
        al = (mx % 16 == 8) && (my % 16 == 8);
        if (!al) begin
            if (mq == OPP[mdir]) mdir = mq;
            mmov = 1;
        end else if (is_open(mx, my, mq)) begin
            mdir = mq;
            mmov = 1;
        end else begin
            mmov = is_open(mx, my, mdir);
        end
        if (mmov != 0) begin
            mx = mx + DC[mdir];
            my = my + DR[mdir];
            if (mx == 7) mx = 632;
            else if (mx == 633) mx = 8;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic set_key(input logic [7:0] k);
        @(negedge Clk) keycode = k;
        @(negedge Clk) keycode = 8'h00;
        case (k)
            8'h1A: mq = 0;
            8'h16: mq = 1;
            8'h04: mq = 2;
            8'h07: mq = 3;
            default: ;
        endcase
    endtask

    // one tick, wait for the service to finish, return cycles spent busy
    task automatic run_tick(output int cyc);
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge Clk);
        end
        if (cyc >= 50) chk("busy_timeout", cyc, 0);
        model_tick();
    endtask

    initial begin
        int cyc;
        logic [10:0] a0;
        vt[0]  = '{8'h00, 311, 376, 2, 1, 3};
        vt[1]  = '{8'h07, 312, 376, 3, 1, 1};
        vt[2]  = '{8'h00, 313, 376, 3, 1, 3};
        vt[3]  = '{8'h00, 314, 376, 3, 1, 1};
        vt[4]  = '{8'h04, 313, 376, 2, 1, 1};
        vt[5]  = '{8'h1A, 312, 376, 2, 1, 1};
        vt[6]  = '{8'h00, 312, 375, 0, 1, 3};
        vt[7]  = '{8'h00, 312, 374, 0, 1, 1};
        vt[8]  = '{8'h55, 312, 373, 0, 1, 1};
        vt[9]  = '{8'h16, 312, 374, 1, 1, 1};
        vt[10] = '{8'h00, 312, 375, 1, 1, 1};
        vt[11] = '{8'h00, 312, 376, 1, 1, 1};
        foreach (maze[r, c]) maze[r][c] = 1'b0;

        // reset values after a long idle
        do_reset();
        repeat (100) @(negedge Clk);
        chk("rst_x", PacmanX, 312);
        chk("rst_y", PacmanY, 376);
        chk("rst_dir", pac_dir, 2);
        chk("rst_moving", moving, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", wall_addr, 0);

        // scripted vectors: open step, reversals, cornering, junk key
        for (int i = 0; i < 12; i++) begin
            if (vt[i].key != 8'h00) set_key(vt[i].key);
            a0 = wall_addr;
            run_tick(cyc);
            chk($sformatf("vec%0d_x", i), PacmanX, vt[i].x);
            chk($sformatf("vec%0d_y", i), PacmanY, vt[i].y);
            chk($sformatf("vec%0d_dir", i), pac_dir, vt[i].dir);
            chk($sformatf("vec%0d_mov", i), moving, vt[i].mov);
            chk($sformatf("vec%0d_cyc", i), cyc, vt[i].cyc);
            if (vt[i].cyc == 1) chk($sformatf("vec%0d_noaddr", i), wall_addr, a0);
        end

        // wall ahead in both queued and current direction
        do_reset();
        maze[23][18] = 1'b1;
        run_tick(cyc);
        chk("wall_x", PacmanX, 312);
        chk("wall_y", PacmanY, 376);
        chk("wall_moving", moving, 0);
        chk("wall_cyc", cyc, 5);
        chk("wall_addr", wall_addr, (23 << 6) | 18);
        maze[23][18] = 1'b0;

        // reset while waiting on the first ROM read
        do_reset();
        set_key(8'h07); run_tick(cyc);
        set_key(8'h04); run_tick(cyc);
        set_key(8'h07);
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        model_reset();
        chk("midrst_x", PacmanX, 312);
        chk("midrst_dir", pac_dir, 2);
        chk("midrst_moving", moving, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", wall_addr, 0);
        repeat (10) @(negedge Clk);
        chk("midrst_hold_x", PacmanX, 312);
        run_tick(cyc);
        chk("midrst_qdir_x", PacmanX, 311);

        // tick while busy is queued once; extra ticks are absorbed
        do_reset();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        repeat (20) @(negedge Clk);
        chk("pend2_x", PacmanX, 310);
        chk("pend2_busy", busy, 0);
        @(negedge Clk) frame_tick = 1'b1;
        repeat (3) @(negedge Clk);
        frame_tick = 1'b0;
        repeat (20) @(negedge Clk);
        chk("pend3_x", PacmanX, 308);

        // tunnel: walk to row 14, then to column 0, wrap both ways
        do_reset();
        set_key(8'h1A);
        repeat (144) run_tick(cyc);
        chk("tun_y", PacmanY, 232);
        set_key(8'h04);
        repeat (304) run_tick(cyc);
        chk("tun_x8", PacmanX, 8);
        run_tick(cyc);
        chk("tun_wrapL_x", PacmanX, 632);
        chk("tun_wrapL_y", PacmanY, 232);
        chk("tun_wrapL_dir", pac_dir, 2);
        set_key(8'h07);
        run_tick(cyc);
        chk("tun_wrapR_x", PacmanX, 8);
        chk("tun_wrapR_dir", pac_dir, 3);

        // random walks through a random maze against the model
        foreach (maze[r, c]) maze[r][c] = ($urandom_range(0, 3) == 0);
        maze[23][19] = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0: set_key(8'h1A);
                    1: set_key(8'h16);
                    2: set_key(8'h04);
                    3: set_key(8'h07);
                    default: set_key(8'($urandom_range(0, 255)));
                endcase
            end
            run_tick(cyc);
            chk("rnd_x", PacmanX, mx);
            chk("rnd_y", PacmanY, my);
            chk("rnd_dir", pac_dir, mdir);
            chk("rnd_mov", moving, mmov);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
